// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and state encoding for the shift-add multiplier
package mult_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fullhalfadder_4b.sv
// rtl/fullhalfadder_4b.sv - 4-bit ripple-carry adder built from one full-adder cell per bit
module fullhalfadder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);

    logic c1;
    logic c2;
    logic c3;

    assign sum[0] = a[0] ^ b[0] ^ cin;
    assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

    assign sum[1] = a[1] ^ b[1] ^ c1;
    assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

    assign sum[2] = a[2] ^ b[2] ^ c2;
    assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));

    assign sum[3] = a[3] ^ b[3] ^ c3;
    assign carry  = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/shift_add_mult_4b.sv
// rtl/shift_add_mult_4b.sv - sequential 4x4 unsigned shift-and-add multiplier, one add per cycle
module shift_add_mult_4b
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   multiplicand,
    input  logic [OP_W-1:0]   multiplier,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q;
    state_e              state_d;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     a_d;
    logic                c_q;
    logic                c_d;
    logic [OP_W-1:0]     q_q;
    logic [OP_W-1:0]     q_d;
    logic [OP_W-1:0]     m_q;
    logic [OP_W-1:0]     m_d;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic [PROD_W-1:0]   product_q;
    logic [PROD_W-1:0]   product_d;

    logic [OP_W-1:0]     add_b;
    logic [OP_W-1:0]     add_sum;
    logic                add_carry;
    logic                accept;
    logic                last_iter;

    assign add_b     = q_q[0] ? m_q : '0;
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_iter = (state_q == RUN) && (cnt_q == 2'd3);

    fullhalfadder_4b u_adder (
        .a     (a_q),
        .b     (add_b),
        .cin   (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == 2'd3) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // The adder carry re-enters the top of A through the shift; C keeps the raw carry of the latest step.
    always_comb begin
        a_d       = a_q;
        c_d       = c_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            m_d   = multiplicand;
            q_d   = multiplier;
            a_d   = '0;
            c_d   = 1'b0;
            cnt_d = 2'd0;
        end else if (state_q == RUN) begin
            {a_d, q_d} = {add_carry, add_sum, q_q[OP_W-1:1]};
            c_d        = add_carry;
            cnt_d      = cnt_q + 2'd1;
            if (last_iter) begin
                product_d = {add_carry, add_sum, q_q[OP_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            c_q       <= 1'b0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= 2'd0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            c_q       <= c_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

    logic unused_c;
    assign unused_c = c_q;

endmodule

// File: tb/tb_shift_add_mult_4b.sv
// tb/tb_shift_add_mult_4b.sv - scoreboard bench for shift_add_mult_4b with random and directed operands
module tb_shift_add_mult_4b;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         errs;
    int         checks;
    int         cyc;
    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic       prev_done;
    logic [7:0] prev_product;

    shift_add_mult_4b dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and polices the handshake every cycle.
    initial begin
        prev_done    = 1'b0;
        prev_product = 8'h00;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done    = 1'b0;
            prev_product = 8'h00;
        end else begin
            check("busy_and_done", int'(busy && done), 0);
            if (done) begin
                check("done_width", int'(prev_done), 0);
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_done: product=%0h with nothing outstanding", product);
                end else begin
                    logic [7:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    if (product != e) begin
                        errs++;
                        $display("FAIL product: got %0h expected %0h", product, e);
                    end
                    check("latency_edges_after_accept", cyc - a, 4);
                end
            end else begin
                check("product_hold", int'(product), int'(prev_product));
            end
            prev_done    = done;
            prev_product = product;
        end
    end

    task automatic issue(input logic [3:0] m, input logic [3:0] q, input bit expect_it);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        if (expect_it) begin
            exp_q.push_back(8'(int'(m) * int'(q)));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $monitor("%0t m=%0d q=%0d busy=%b done=%b product=%h",
                 $time, multiplicand, multiplier, busy, done, product);
    end

    initial begin
        errs         = 0;
        checks       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 4'h0;
        multiplier   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Boundary operands
        issue(4'd15, 4'd15, 1'b1); drain();
        issue(4'd0,  4'd0,  1'b1); drain();
        issue(4'd15, 4'd0,  1'b1); drain();
        issue(4'd1,  4'd15, 1'b1); drain();

        // Reset at E2 of a 9x6 run abandons it
        issue(4'd9, 4'd6, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_product", int'(product), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        issue(4'd9, 4'd6, 1'b1); drain();

        // Start pulsed while running 7x3 must be ignored
        issue(4'd7, 4'd3, 1'b1);
        @(posedge clk);
        issue(4'd5, 4'd13, 1'b0);
        drain();
        repeat (6) @(posedge clk);

        // Back-to-back: second start held in the DONE cycle
        issue(4'd6, 4'd5, 1'b1);
        repeat (4) @(posedge clk);
        issue(4'd12, 4'd11, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b_hold_first", int'(product), 8'h1E);
        drain();

        // Random regression against plain multiplication
        for (int i = 0; i < 10; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
